int_writeback_stage: RTL and testbench



---
 rtl/int_writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_int_writeback_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_writeback_stage.sv
// Writeback stage behind the integer exec pipeline: metadata register, result FIFO,
// masked register-file write handshake, and retire pulses. Optional bypass: INT_WB_BYPASS_EN.
module int_writeback_stage #(
   parameter int VEC_WIDTH = 16,
   parameter int DWIDTH    = 32,
   parameter int REG_BITS  = 5,
   parameter int RID_BITS  = 3,
   parameter int DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          issue_valid,
   input  logic                          issue_wb_en,
   input  logic [REG_BITS-1:0]           issue_dst,
   input  logic [VEC_WIDTH-1:0]          issue_mask,
   input  logic [RID_BITS-1:0]           issue_rid,
   input  logic [VEC_WIDTH*DWIDTH-1:0]   exec_out,
   output logic                          stall_o,
   output logic                          wb_valid,
   input  logic                          wb_ready,
   output logic [REG_BITS-1:0]           wb_reg,
   output logic [VEC_WIDTH-1:0]          wb_mask,
   output logic [VEC_WIDTH*DWIDTH-1:0]   wb_data,
   output logic                          done_valid,
   output logic [RID_BITS-1:0]           done_rid,
   output logic [$clog2(DEPTH):0]        occupancy
);

   localparam int PTR_BITS  = $clog2(DEPTH);
   localparam int CNT_BITS  = PTR_BITS + 1;
   localparam int DATA_BITS = VEC_WIDTH * DWIDTH;
   localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

   typedef struct packed {
      logic                 wb_en;
      logic [REG_BITS-1:0]  dst;
      logic [VEC_WIDTH-1:0] mask;
      logic [RID_BITS-1:0]  rid;
      logic [DATA_BITS-1:0] data;
   } entry_t;

   // Metadata travelling alongside the op through the exec latency
   logic                 meta_valid;
   logic                 meta_wb_en;
   logic [REG_BITS-1:0]  meta_dst;
   logic [VEC_WIDTH-1:0] meta_mask;
   logic [RID_BITS-1:0]  meta_rid;

   entry_t               mem [DEPTH];
   logic [PTR_BITS-1:0]  wr_ptr;
   logic [PTR_BITS-1:0]  rd_ptr;
   logic [CNT_BITS-1:0]  count;

   entry_t               incoming;
   entry_t               head;
   entry_t               out_entry;
   logic                 empty;
   logic                 full;
   logic                 head_writes;
   logic                 push;
   logic                 pop;
   logic                 bypass;

   assign incoming    = '{wb_en: meta_wb_en, dst: meta_dst, mask: meta_mask,
                          rid: meta_rid, data: exec_out};
   assign head        = mem[rd_ptr];
   assign empty       = (count == '0);
   assign full        = (count == FULL_CNT);
   assign head_writes = head.wb_en && (head.mask != '0);
   assign occupancy   = count;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned (no latches).
   always_comb begin
      pop       = 1'b0;
      bypass    = 1'b0;
      wb_valid  = 1'b0;
      out_entry = head;
      if (!empty) begin
         wb_valid = head_writes;
         pop      = !head_writes || wb_ready;
      end
`ifdef INT_WB_BYPASS_EN
      else if (meta_valid) begin
         out_entry = incoming;
         wb_valid  = meta_wb_en && (meta_mask != '0);
         bypass    = !wb_valid || wb_ready;
      end
`endif
      push    = meta_valid && !bypass && (!full || pop);
      stall_o = meta_valid && full && !pop;
   end

   // Outputs read as zero whenever no write is offered, so stale storage never leaks out
   always_comb begin
      wb_reg  = '0;
      wb_mask = '0;
      wb_data = '0;
      if (wb_valid) begin
         wb_reg  = out_entry.dst;
         wb_mask = out_entry.mask;
         wb_data = out_entry.data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_valid <= 1'b0;
         meta_wb_en <= 1'b0;
         meta_dst   <= '0;
         meta_mask  <= '0;
         meta_rid   <= '0;
      end else if (!stall_o) begin
         meta_valid <= issue_valid;
         meta_wb_en <= issue_wb_en;
         meta_dst   <= issue_dst;
         meta_mask  <= issue_mask;
         meta_rid   <= issue_rid;
      end
   end

   // NOTE: FIFO storage is not reset; pointers and count are, and outputs are gated by wb_valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= incoming;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Retire pulse follows the pop (or bypass retire) by one edge, in program order
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done_valid <= 1'b0;
         done_rid   <= '0;
      end else begin
         done_valid <= pop || bypass;
         if (pop)         done_rid <= head.rid;
         else if (bypass) done_rid <= meta_rid;
      end
   end

   a_wb_hold: assert property (@(posedge clk) disable iff (!rstn)
      wb_valid && !wb_ready |=> wb_valid && $stable(wb_reg) && $stable(wb_mask) && $stable(wb_data));

   a_count_bound: assert property (@(posedge clk) disable iff (!rstn) count <= FULL_CNT);

endmodule

// File: tb/tb_int_writeback_stage.sv
// Randomized self-checking bench for int_writeback_stage against a queue-based reference model.
module tb_int_writeback_stage;
   localparam int VEC_WIDTH = 16;
   localparam int DWIDTH    = 32;
   localparam int REG_BITS  = 5;
   localparam int RID_BITS  = 3;
   localparam int DEPTH     = 4;
   localparam int DATA_BITS = VEC_WIDTH * DWIDTH;
   localparam int OCC_BITS  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic                 wb_en;
      logic [REG_BITS-1:0]  dst;
      logic [VEC_WIDTH-1:0] mask;
      logic [RID_BITS-1:0]  rid;
      logic [DATA_BITS-1:0] data;
   } op_t;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic                   issue_valid;
   logic                   issue_wb_en;
   logic [REG_BITS-1:0]    issue_dst;
   logic [VEC_WIDTH-1:0]   issue_mask;
   logic [RID_BITS-1:0]    issue_rid;
   logic [DATA_BITS-1:0]   exec_out;
   logic                   stall_o;
   logic                   wb_valid;
   logic                   wb_ready;
   logic [REG_BITS-1:0]    wb_reg;
   logic [VEC_WIDTH-1:0]   wb_mask;
   logic [DATA_BITS-1:0]   wb_data;
   logic                   done_valid;
   logic [RID_BITS-1:0]    done_rid;
   logic [OCC_BITS-1:0]    occupancy;

   int_writeback_stage #(
      .VEC_WIDTH(VEC_WIDTH), .DWIDTH(DWIDTH), .REG_BITS(REG_BITS),
      .RID_BITS(RID_BITS), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dst(issue_dst),
      .issue_mask(issue_mask), .issue_rid(issue_rid), .exec_out(exec_out),
      .stall_o(stall_o), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_reg(wb_reg), .wb_mask(wb_mask), .wb_data(wb_data),
      .done_valid(done_valid), .done_rid(done_rid), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [DATA_BITS-1:0] got,
                        input logic [DATA_BITS-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the FIFO is a plain queue, the metadata slot a single op
   op_t                  q[$];
   op_t                  to_issue[$];
   op_t                  m_meta;
   logic                 m_meta_valid;
   logic                 m_done_valid;
   logic [RID_BITS-1:0]  m_done_rid;
   logic                 exec_load;
   logic [DATA_BITS-1:0] exec_next;
   int                   issue_pct;
   int                   ready_pct;

   function automatic logic writes(input op_t o);
      return o.wb_en && (o.mask != '0);
   endfunction

   function automatic op_t mk_op(input logic en, input logic [REG_BITS-1:0] dst,
                                 input logic [VEC_WIDTH-1:0] mask, input logic [RID_BITS-1:0] rid);
      op_t o;
      o.wb_en = en;
      o.dst   = dst;
      o.mask  = mask;
      o.rid   = rid;
      for (int l = 0; l < VEC_WIDTH; l++) o.data[l*DWIDTH +: DWIDTH] = $urandom();
      return o;
   endfunction

   function automatic op_t rand_op(input logic [RID_BITS-1:0] rid);
      logic [VEC_WIDTH-1:0] m;
      m = ($urandom_range(6) == 0) ? '0 : VEC_WIDTH'($urandom());
      return mk_op($urandom_range(9) != 0, REG_BITS'($urandom()), m, rid);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stall"}, stall_o, 0);
      check({tag, "_wb_valid"}, wb_valid, 0);
      check({tag, "_wb_reg"}, wb_reg, 0);
      check({tag, "_wb_mask"}, wb_mask, 0);
      check({tag, "_wb_data"}, wb_data, 0);
      check({tag, "_done_valid"}, done_valid, 0);
      check({tag, "_done_rid"}, done_rid, 0);
      check({tag, "_occupancy"}, occupancy, 0);
   endtask

   task automatic clear_model();
      q.delete();
      to_issue.delete();
      m_meta       = '0;
      m_meta_valid = 1'b0;
      m_done_valid = 1'b0;
      m_done_rid   = '0;
      exec_load    = 1'b0;
      exec_next    = '0;
   endtask

   // One clock: drive at negedge, compare just after, advance the model at posedge
   task automatic step();
      op_t  head, pres, src;
      logic e_pop, e_byp, e_push, e_stall, e_wbv;
      @(negedge clk);
      if (exec_load) exec_out = exec_next;
      pres = '0;
      issue_valid = 1'b0;
      if (to_issue.size() > 0 && $urandom_range(99) < issue_pct) begin
         pres = to_issue[0];
         issue_valid = 1'b1;
      end
      issue_wb_en = pres.wb_en;
      issue_dst   = pres.dst;
      issue_mask  = pres.mask;
      issue_rid   = pres.rid;
      wb_ready    = ($urandom_range(99) < ready_pct);
      #1;
      head  = '0;
      src   = '0;
      e_pop = 1'b0;
      e_byp = 1'b0;
      e_wbv = 1'b0;
      if (q.size() > 0) begin
         head  = q[0];
         src   = head;
         e_wbv = writes(head);
         e_pop = !e_wbv || wb_ready;
      end
`ifdef INT_WB_BYPASS_EN
      else if (m_meta_valid) begin
         src   = m_meta;
         e_wbv = writes(m_meta);
         e_byp = !e_wbv || wb_ready;
      end
`endif
      e_push  = m_meta_valid && !e_byp && (q.size() < DEPTH || e_pop);
      e_stall = m_meta_valid && (q.size() == DEPTH) && !e_pop;
      check("stall_o", stall_o, e_stall);
      check("wb_valid", wb_valid, e_wbv);
      if (e_wbv) begin
         check("wb_reg", wb_reg, src.dst);
         check("wb_mask", wb_mask, src.mask);
         check("wb_data", wb_data, src.data);
      end
      check("occupancy", occupancy, q.size());
      check("done_valid", done_valid, m_done_valid);
      if (m_done_valid) check("done_rid", done_rid, m_done_rid);
      @(posedge clk);
      m_done_valid = e_pop || e_byp;
      if (e_pop)      m_done_rid = head.rid;
      else if (e_byp) m_done_rid = m_meta.rid;
      if (e_pop)  void'(q.pop_front());
      if (e_push) q.push_back(m_meta);
      exec_load = !e_stall;
      if (!e_stall) begin
         m_meta_valid = issue_valid;
         m_meta       = pres;
         exec_next    = pres.data;
         if (issue_valid) void'(to_issue.pop_front());
      end
   endtask

   task automatic reset_mid();
      @(negedge clk);
      #2;
      rstn = 1'b0;
      issue_valid = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      clear_model();
      @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   initial begin
      logic [RID_BITS-1:0] rid_ctr;
      op_t o;
      rstn        = 1'b0;
      issue_valid = 1'b0;
      issue_wb_en = 1'b0;
      issue_dst   = '0;
      issue_mask  = '0;
      issue_rid   = '0;
      exec_out    = '0;
      wb_ready    = 1'b0;
      issue_pct   = 100;
      ready_pct   = 100;
      clear_model();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rstn = 1'b1;

      // Single op with every lane = 5
      o = mk_op(1'b1, 5'd7, 16'hFFFF, 3'd2);
      for (int l = 0; l < VEC_WIDTH; l++) o.data[l*DWIDTH +: DWIDTH] = 32'h5;
      to_issue.push_back(o);
      repeat (5) step();

      // Back-pressure: six ops into a four-entry FIFO, then drain through full+pop
      ready_pct = 0;
      for (int r = 0; r < 6; r++)
         to_issue.push_back(mk_op(1'b1, REG_BITS'($urandom()), VEC_WIDTH'($urandom()) | 16'h1,
                                  RID_BITS'(r)));
      repeat (8) step();
      #1;
      check("bp_occupancy_full", occupancy, DEPTH);
      check("bp_stall_full", stall_o, 1);
      ready_pct = 100;
      repeat (12) step();
      #1;
      check("bp_drained", occupancy, 0);

      // Non-writing ops retire without a write, even with the register file blocked
      ready_pct = 0;
      to_issue.push_back(mk_op(1'b0, 5'd9, 16'h00F0, 3'd3));
      to_issue.push_back(mk_op(1'b1, 5'd10, 16'h0000, 3'd4));
      repeat (5) step();

      // Reset with entries queued: no retire pulses for flushed ops
      for (int r = 0; r < 4; r++) to_issue.push_back(rand_op(RID_BITS'(r)));
      for (int r = 0; r < 4; r++) to_issue[r].wb_en = 1'b1;
      for (int r = 0; r < 4; r++) to_issue[r].mask[0] = 1'b1;
      repeat (4) step();
      reset_mid();
      ready_pct = 100;
      repeat (4) step();

      // Random traffic
      issue_pct = 70;
      ready_pct = 60;
      rid_ctr   = '0;
      for (int i = 0; i < 3000; i++) begin
         if (to_issue.size() < 2) begin
            to_issue.push_back(rand_op(rid_ctr));
            rid_ctr = rid_ctr + 1'b1;
         end
         step();
      end
      issue_pct = 0;
      ready_pct = 100;
      repeat (10) step();
      #1;
      check("final_empty", occupancy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
